// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants and helpers for the memory access controller
package mem_ctrl_pkg;

    typedef logic [1:0] mem_type_t;

    // Access sizes
    localparam mem_type_t MEM_B = 2'b00;
    localparam mem_type_t MEM_H = 2'b01;
    localparam mem_type_t MEM_W = 2'b10;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Width of the wait-state counter
    localparam int CNT_W = 4;

    // Halfwords need an even address, words (and the unused 2'b11 code) a multiple of four
    function automatic logic is_misaligned(input mem_type_t t, input logic [1:0] off);
        case (t)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline-side and RAM-side signal bundle of the controller
interface mem_access_ctrl_if;
    import mem_ctrl_pkg::*;

    // Pipeline side
    logic        mem_ren;
    logic        mem_wen;
    mem_type_t   mem_type;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] bad_vaddr;

    // RAM side
    logic        ram_cs;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport slave (
        input  mem_ren, mem_wen, mem_type, mem_signed, mem_addr, mem_wdata, flush, ram_dout,
        output mem_rdata, stall, exc_adel, exc_ades, bad_vaddr, ram_cs, ram_we, ram_addr, ram_din
    );

    modport master (
        output mem_ren, mem_wen, mem_type, mem_signed, mem_addr, mem_wdata, flush, ram_dout,
        input  mem_rdata, stall, exc_adel, exc_ades, bad_vaddr, ram_cs, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_access_ctrl_align.sv
// rtl/mem_access_ctrl_align.sv - lane extraction, lane merge and alignment check
module mem_align
    import mem_ctrl_pkg::*;
(
    input  mem_type_t   acc_type,
    input  logic        sign_ext,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte      = rword[{byte_off, 3'b000} +: 8];
    assign rhalf      = rword[{byte_off[1], 4'b0000} +: 16];
    assign misaligned = is_misaligned(acc_type, byte_off);

    // Right-justify and extend the load lane; splice the store lane into the old word
    always_comb begin
        load_data = rword;
        merged    = wdata;
        case (acc_type)
            MEM_B: begin
                load_data = {{24{sign_ext & rbyte[7]}}, rbyte};
                merged    = rword;
                merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            MEM_H: begin
                load_data = {{16{sign_ext & rhalf[15]}}, rhalf};
                merged    = rword;
                merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rword;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller turning B/H/W accesses into word RAM cycles
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    mem_type_t        lat_type;
    logic             lat_signed;
    logic [1:0]       lat_off;
    logic [31:0]      lat_wdata;
    logic             lat_store;
    logic [31:0]      rdata_q;
    logic             adel_q;
    logic             ades_q;
    logic [31:0]      bva_q;
    logic [31:0]      ram_addr_q;
    logic [31:0]      ram_din_q;

    logic             req;
    logic             in_idle;
    logic             last;
    mem_type_t        al_type;
    logic             al_signed;
    logic [1:0]       al_off;
    logic [31:0]      al_wdata;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    logic             misaligned;

    assign req     = bus.mem_ren | bus.mem_wen;
    assign in_idle = (state == ST_IDLE);
    assign last    = (cnt == CNT_W'(WAIT_CYCLES - 1));

    // The alignment check looks at the live request; extraction and merge use the latched one
    assign al_type   = in_idle ? bus.mem_type       : lat_type;
    assign al_signed = in_idle ? bus.mem_signed     : lat_signed;
    assign al_off    = in_idle ? bus.mem_addr[1:0]  : lat_off;
    assign al_wdata  = in_idle ? bus.mem_wdata      : lat_wdata;

    mem_align u_align (
        .acc_type   (al_type),
        .sign_ext   (al_signed),
        .byte_off   (al_off),
        .rword      (bus.ram_dout),
        .wdata      (al_wdata),
        .load_data  (load_data),
        .merged     (merged),
        .misaligned (misaligned)
    );

    // Hold the pipeline until DONE; a flushed request in IDLE never stalls
    assign bus.stall     = rst & req & (state != ST_DONE) & ~(in_idle & bus.flush);
    assign bus.ram_cs    = rst & ((state == ST_RD) | (state == ST_WR));
    assign bus.ram_we    = rst & (state == ST_WR);
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.exc_adel  = adel_q;
    assign bus.exc_ades  = ades_q;
    assign bus.bad_vaddr = bva_q;

    // FSM, wait counter and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_type   <= MEM_B;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_wdata  <= '0;
            lat_store  <= 1'b0;
            rdata_q    <= '0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            bva_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req && !bus.flush) begin
                        lat_type   <= bus.mem_type;
                        lat_signed <= bus.mem_signed;
                        lat_off    <= bus.mem_addr[1:0];
                        lat_wdata  <= bus.mem_wdata;
                        lat_store  <= bus.mem_wen;
                        if (misaligned) begin
                            adel_q  <= ~bus.mem_wen;
                            ades_q  <= bus.mem_wen;
                            bva_q   <= bus.mem_addr;
                            rdata_q <= '0;
                            state   <= ST_DONE;
                        end else begin
                            ram_addr_q <= {2'b00, bus.mem_addr[31:2]};
                            if (bus.mem_wen && bus.mem_type == MEM_W) begin
                                ram_din_q <= bus.mem_wdata;
                                state     <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (last) begin
                        cnt <= '0;
                        if (lat_store) begin
                            ram_din_q <= merged;
                            state     <= ST_WR;
                        end else begin
                            rdata_q <= load_data;
                            state   <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    adel_q <= 1'b0;
                    ades_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst4, sel4;
    logic        ren, wen, sgn, flush;
    mem_type_t   typ;
    logic [31:0] addr, wdata;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_data;
    logic [31:0] ram1 [0:15];
    logic [31:0] ram4 [0:15];
    int          passed = 0;
    int          total  = 0;

    mem_access_ctrl_if if1 ();
    mem_access_ctrl_if if4 ();

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    mem_access_ctrl #(.WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

    assign if1.mem_ren    = ren & ~sel4;
    assign if1.mem_wen    = wen & ~sel4;
    assign if1.mem_type   = typ;
    assign if1.mem_signed = sgn;
    assign if1.mem_addr   = addr;
    assign if1.mem_wdata  = wdata;
    assign if1.flush      = flush;
    assign if1.ram_dout   = (if1.ram_addr < 32'd16) ? ram1[if1.ram_addr[3:0]] : 32'h0;

    assign if4.mem_ren    = ren & sel4;
    assign if4.mem_wen    = wen & sel4;
    assign if4.mem_type   = typ;
    assign if4.mem_signed = sgn;
    assign if4.mem_addr   = addr;
    assign if4.mem_wdata  = wdata;
    assign if4.flush      = flush;
    assign if4.ram_dout   = (if4.ram_addr < 32'd16) ? ram4[if4.ram_addr[3:0]] : 32'h0;

    // Falling-edge RAMs, with a preload port driven from the bench
    always @(negedge clk) begin
        if (ld_en) begin
            ram1[ld_idx] <= ld_data;
            ram4[ld_idx] <= ld_data;
        end else begin
            if (if1.ram_cs && if1.ram_we && if1.ram_addr < 32'd16) ram1[if1.ram_addr[3:0]] <= if1.ram_din;
            if (if4.ram_cs && if4.ram_we && if4.ram_addr < 32'd16) ram4[if4.ram_addr[3:0]] <= if4.ram_din;
        end
    end

    logic        stall_s, cs_s, we_s, adel_s, ades_s;
    logic [31:0] rdata_s, bva_s, raddr_s;
    assign stall_s = sel4 ? if4.stall     : if1.stall;
    assign cs_s    = sel4 ? if4.ram_cs    : if1.ram_cs;
    assign we_s    = sel4 ? if4.ram_we    : if1.ram_we;
    assign adel_s  = sel4 ? if4.exc_adel  : if1.exc_adel;
    assign ades_s  = sel4 ? if4.exc_ades  : if1.exc_ades;
    assign rdata_s = sel4 ? if4.mem_rdata : if1.mem_rdata;
    assign bva_s   = sel4 ? if4.bad_vaddr : if1.bad_vaddr;
    assign raddr_s = sel4 ? if4.ram_addr  : if1.ram_addr;

    // Results of the most recent access
    int          done_c, cs_c, we_c;
    logic [31:0] r_rdata, r_bva, r_raddr;
    logic        r_adel, r_ades;

    // One access: request in cycle 0, flush raised in cycle fc (-1 = never), DONE = first cycle without stall
    task automatic run(input bit s4, input bit w, input bit r, input mem_type_t t, input bit sg,
                       input logic [31:0] a, input logic [31:0] d, input int fc);
        @(posedge clk); #1;
        sel4 = s4; ren = r; wen = w; typ = t; sgn = sg; addr = a; wdata = d; flush = (fc == 0);
        done_c = -1; cs_c = 0; we_c = 0; r_raddr = 32'h0;
        r_rdata = 32'h0; r_bva = 32'h0; r_adel = 1'b0; r_ades = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cs_s) begin cs_c++; r_raddr = raddr_s; end
            if (we_s) we_c++;
            if (!stall_s) begin
                done_c = c; r_rdata = rdata_s; r_bva = bva_s; r_adel = adel_s; r_ades = ades_s;
                break;
            end
            @(posedge clk); #1;
            flush = (fc == c + 1);
        end
        if (done_c < 0) begin
            total++;
            $display("FAIL timeout: stall never dropped within 40 cycles (addr %h)", a);
        end
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0; flush = 1'b0;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = idx; ld_data = val;
        @(negedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; rst4 = 1'b0; sel4 = 1'b0; ren = 1'b1; wen = 1'b0; sgn = 1'b0; flush = 1'b0;
        typ = MEM_W; addr = 32'h0; wdata = 32'h0; ld_en = 1'b0; ld_idx = 4'd0; ld_data = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if (if1.stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", if1.stall); else passed++;
        total++;
        if ({if1.ram_cs, if1.ram_we, if1.exc_adel, if1.exc_ades} !== 4'b0)
            $display("FAIL reset_strobes: got %b exp 0000", {if1.ram_cs, if1.ram_we, if1.exc_adel, if1.exc_ades});
        else passed++;
        total++;
        if ({if1.mem_rdata, if1.bad_vaddr, if1.ram_addr, if1.ram_din} !== 128'h0)
            $display("FAIL reset_data: got %h exp 0", {if1.mem_rdata, if1.bad_vaddr, if1.ram_addr, if1.ram_din});
        else passed++;
        ren = 1'b0;
        rst1 = 1'b1; rst4 = 1'b1;
        preload(4'd3, 32'h8899AABB);
    endtask

    task automatic test_lw();
        run(0, 0, 1, MEM_W, 0, 32'h0C, 32'h0, -1);
        total++;
        if (done_c !== 2) $display("FAIL lw_done_cycle: got %0d exp 2", done_c); else passed++;
        total++;
        if (r_rdata !== 32'h8899AABB) $display("FAIL lw_rdata: got %h exp 8899aabb", r_rdata); else passed++;
        total++;
        if (r_raddr !== 32'd3 || cs_c !== 1 || we_c !== 0)
            $display("FAIL lw_ram: got addr %h cs %0d we %0d exp 3/1/0", r_raddr, cs_c, we_c);
        else passed++;
    endtask

    task automatic test_partial_loads();
        mem_type_t   t_tab [4] = '{MEM_B, MEM_B, MEM_H, MEM_H};
        logic        s_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_tab [4] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E};
        logic [31:0] e_tab [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
        for (int i = 0; i < 4; i++) begin
            run(0, 0, 1, t_tab[i], s_tab[i], a_tab[i], 32'h0, -1);
            total++;
            if (r_rdata !== e_tab[i] || done_c !== 2)
                $display("FAIL load_%0d: got %h done %0d exp %h done 2", i, r_rdata, done_c, e_tab[i]);
            else passed++;
        end
    endtask

    task automatic test_sb();
        run(0, 1, 0, MEM_B, 0, 32'h0D, 32'h12345611, -1);
        total++;
        if (ram1[3] !== 32'h889911BB) $display("FAIL sb_mem: got %h exp 889911bb", ram1[3]); else passed++;
        total++;
        if (done_c !== 3 || cs_c !== 2 || we_c !== 1)
            $display("FAIL sb_timing: got done %0d cs %0d we %0d exp 3/2/1", done_c, cs_c, we_c);
        else passed++;
    endtask

    task automatic test_sw();
        run(0, 1, 0, MEM_W, 0, 32'h0C, 32'hDEADBEEF, -1);
        total++;
        if (ram1[3] !== 32'hDEADBEEF) $display("FAIL sw_mem: got %h exp deadbeef", ram1[3]); else passed++;
        total++;
        if (done_c !== 2 || cs_c !== 1 || we_c !== 1)
            $display("FAIL sw_timing: got done %0d cs %0d we %0d exp 2/1/1", done_c, cs_c, we_c);
        else passed++;
    endtask

    task automatic test_misaligned();
        run(0, 0, 1, MEM_W, 1, 32'h0E, 32'h0, -1);
        total++;
        if (r_adel !== 1'b1 || r_ades !== 1'b0 || r_bva !== 32'h0E)
            $display("FAIL lw_adel: got adel %b ades %b bva %h exp 1/0/0000000e", r_adel, r_ades, r_bva);
        else passed++;
        total++;
        if (r_rdata !== 32'h0 || cs_c !== 0 || done_c !== 1)
            $display("FAIL lw_adel_side: got rdata %h cs %0d done %0d exp 0/0/1", r_rdata, cs_c, done_c);
        else passed++;
        run(0, 1, 0, MEM_H, 0, 32'h0F, 32'h0000ABCD, -1);
        total++;
        if (r_ades !== 1'b1 || r_adel !== 1'b0 || r_bva !== 32'h0F)
            $display("FAIL sh_ades: got ades %b adel %b bva %h exp 1/0/0000000f", r_ades, r_adel, r_bva);
        else passed++;
        total++;
        if (ram1[3] !== 32'hDEADBEEF || cs_c !== 0)
            $display("FAIL sh_ades_mem: got %h cs %0d exp deadbeef cs 0", ram1[3], cs_c);
        else passed++;
    endtask

    task automatic test_flush_idle();
        int cs_seen;
        run(0, 0, 1, MEM_W, 0, 32'h0C, 32'h0, 0);
        total++;
        if (done_c !== 0 || cs_c !== 0)
            $display("FAIL flush_idle: got stall-drop cycle %0d cs %0d exp 0/0", done_c, cs_c);
        else passed++;
        cs_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (if1.ram_cs) cs_seen++;
        end
        total++;
        if (cs_seen !== 0) $display("FAIL flush_idle_quiet: got %0d cs cycles exp 0", cs_seen); else passed++;
    endtask

    task automatic test_flush_rd();
        run(0, 1, 0, MEM_B, 0, 32'h0E, 32'h00000077, 1);
        total++;
        if (ram1[3] !== 32'hDE77BEEF || done_c !== 3)
            $display("FAIL flush_rd_sb: got %h done %0d exp de77beef done 3", ram1[3], done_c);
        else passed++;
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        sel4 = 1'b1; wen = 1'b1; ren = 1'b0; typ = MEM_W; addr = 32'h0C; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #1;
        total++;
        if (if4.ram_we !== 1'b1 || if4.stall !== 1'b1)
            $display("FAIL w4_in_wr: got we %b stall %b exp 1/1", if4.ram_we, if4.stall);
        else passed++;
        #1 rst4 = 1'b0;
        #1;
        total++;
        if ({if4.stall, if4.ram_cs, if4.ram_we, if4.exc_adel, if4.exc_ades} !== 5'b0)
            $display("FAIL w4_reset_strobes: got %b exp 00000",
                     {if4.stall, if4.ram_cs, if4.ram_we, if4.exc_adel, if4.exc_ades});
        else passed++;
        total++;
        if ({if4.mem_rdata, if4.bad_vaddr, if4.ram_addr, if4.ram_din} !== 128'h0)
            $display("FAIL w4_reset_data: got %h exp 0", {if4.mem_rdata, if4.bad_vaddr, if4.ram_addr, if4.ram_din});
        else passed++;
        wen = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        run(1, 0, 1, MEM_W, 0, 32'h0C, 32'h0, -1);
        total++;
        if (r_rdata !== 32'hCAFEF00D || done_c !== 5 || cs_c !== 4)
            $display("FAIL w4_lw_after_reset: got %h done %0d cs %0d exp cafef00d/5/4", r_rdata, done_c, cs_c);
        else passed++;
    endtask

    task automatic test_w4_sb();
        run(1, 1, 0, MEM_B, 0, 32'h0C, 32'hFFFFFF55, -1);
        total++;
        if (ram4[3] !== 32'hCAFEF055) $display("FAIL w4_sb_mem: got %h exp cafef055", ram4[3]); else passed++;
        total++;
        if (done_c !== 9 || cs_c !== 8 || we_c !== 4)
            $display("FAIL w4_sb_timing: got done %0d cs %0d we %0d exp 9/8/4", done_c, cs_c, we_c);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_partial_loads();
        test_sb();
        test_sw();
        test_misaligned();
        test_flush_idle();
        test_flush_rd();
        test_reset_midop();
        test_w4_sb();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the pipelined MIPS core. It sits between the MEM pipeline stage and the word-organised data RAM. It turns byte, halfword and word loads and stores into word RAM cycles, performing read-modify-write for partial stores and sign or zero extension for loads. It holds the pipeline with `stall` for the programmed RAM latency, and raises address-error exceptions for the interrupt logic.

## Interface
- `WAIT_CYCLES`, default 1: cycles each RAM read or write phase is held. Legal range 1..15.
- `clk` in 1: sole clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_ren` in 1: load request.
- `mem_wen` in 1: store request. Wins if both `mem_ren` and `mem_wen` are high.
- `mem_type` in 2: access size, one of `MEM_B`, `MEM_H`, `MEM_W`.
- `mem_signed` in 1: load extension; 1 = sign-extend, 0 = zero-extend.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, right-aligned.
- `flush` in 1: kill the pending request. Sampled in IDLE only.
- `mem_rdata` out 32: extended load result, valid in DONE.
- `stall` out 1: pipeline hold.
- `exc_adel` out 1, `exc_ades` out 1: load or store address error, valid in DONE.
- `bad_vaddr` out 32: faulting byte address.
- `ram_cs` out 1, `ram_we` out 1: RAM select and write strobe.
- `ram_addr` out 32: word address, equal to {2'b00, addr[31:2]}.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data.

## Operation
- States: IDLE, RD, WR, DONE.
- Request = `mem_ren | mem_wen`.
- `stall` = request & (state != DONE). It is combinational and also covers the IDLE request cycle.
- In IDLE with a request and `flush` = 0, the controller latches addr, type, signed, wdata and direction, then moves:
  - If misaligned (H with addr[0] = 1, or W with addr[1:0] != 0), go to DONE. Set `exc_adel` (load) or `exc_ades` (store) and set `bad_vaddr` to the address. No RAM cycle is issued.
  - For a load, or a B/H store, go to RD.
  - For a W store, go to WR.
- In IDLE with `flush` = 1, the request is ignored: no RAM access, no exception, `stall` = 0.
- RD: `ram_cs` = 1 and `ram_we` = 0 for WAIT_CYCLES cycles, timed by a 4-bit counter. On the last cycle, `ram_dout` is captured.
  - A load then goes to DONE.
  - A partial store merges the new lane(s) into the captured word and goes to WR.
- WR: `ram_cs` = 1, `ram_we` = 1 and `ram_din` = the merged or full word, held for WAIT_CYCLES cycles. Then go to DONE.
- DONE: lasts one cycle. `stall` = 0 and the pipeline advances. Next state is IDLE unconditionally.
- Lanes are little-endian: byte n occupies bits [8n+7:8n], and a halfword at addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
- Loads: the selected lane is right-justified and extended per `mem_signed`. A W load ignores `mem_signed`. The result is 0 on an exception.
- `flush` outside IDLE is ignored. An in-flight access always completes, so a store is never torn.
- Outside RD and WR, `ram_cs` = `ram_we` = 0 and `ram_addr` / `ram_din` hold their last values.
- Out-of-range addresses are passed through unchanged; the RAM returns 0 for them.

## Timing
- Reset values: state IDLE, counter 0, and all of `mem_rdata`, `bad_vaddr`, `ram_addr`, `ram_din`, `ram_cs`, `ram_we`, `exc_*` are 0.
- Under reset, `stall` is forced to 0 and `ram_we` drops immediately.
- The request is presented in cycle 0. With W = WAIT_CYCLES, the DONE cycle is:
  - aligned load or W store: cycle W+1;
  - B/H store: cycle 2W+1;
  - misaligned access: cycle 1.
- Back-to-back requests: DONE is followed by one IDLE cycle before the next access phase.
- Reset asserted mid-operation aborts to IDLE asynchronously. A partially written word is whatever the RAM captured before reset.
- The RAM samples on the falling edge, so W = 1 is the minimum. Read data is stable before the rising edge that ends RD.

## Structure
- Package `mem_ctrl_pkg` holds:
  - `MEM_B` = 2'b00, `MEM_H` = 2'b01, `MEM_W` = 2'b10;
  - the state encoding;
  - `CNT_W` = 4.
- Sub-module `mem_align` is purely combinational. It performs lane extraction with extension for loads, lane merge for stores, and the misalignment check. The top level holds the FSM, counter and registers.

## Test plan
- W=1, word[3]=0x8899AABB; LW 0x0C → `stall` high in cycles 0–1, `mem_rdata`=0x8899AABB in cycle 2, `ram_addr`=3.
- LB 0x0D signed → 0xFFFFFFAA; LBU 0x0D → 0x000000AA; LH 0x0E signed → 0xFFFF8899; LHU 0x0E → 0x00008899.
- W=1, SB 0x0D with wdata 0x12345611 → word[3]=0x889911BB, one RD cycle then one WR cycle, DONE in cycle 3; SW 0x0C with 0xDEADBEEF → word[3]=0xDEADBEEF, DONE in cycle 2.
- LW 0x0E → `exc_adel`=1, `bad_vaddr`=0x0E, `mem_rdata`=0, `ram_cs` never high; SH 0x0F → `exc_ades`=1, RAM unchanged.
- W=4, SW with `rst` pulled low in the 2nd WR cycle → all outputs 0 in the same cycle, IDLE after release, next LW succeeds.
- `flush`=1 with LW in IDLE → `stall`=0, no `ram_cs`. `flush` raised during RD of an SB → the store still completes and memory is updated.
